// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// The IFU_MISALIGN_TRAP_EN macro is consumed by instr_fetch_unit, not here.
package ifu_pkg;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_WAIT  = 2'd1,
        S_VALID = 2'd2,
        S_HALT  = 2'd3
    } ifu_state_e;

    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

    localparam logic [1:0]  TGT_PC_IMM  = 2'b01;
    localparam logic [1:0]  TGT_RS1_IMM = 2'b10;

endpackage

// File: rtl/next_pc_gen.sv
// Combinational next-PC selection for the retiring instruction.
// Outputs the raw target and whether a taken target is misaligned (bit 1 set).
module next_pc_gen
    import ifu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm_ext,
    input  logic [XLEN-1:0] alu_result,
    input  logic            branch,
    input  logic            jump,
    input  logic            cond_true,
    input  logic [1:0]      target_src,
    output logic [XLEN-1:0] next_pc,
    output logic            misalign
);

    logic            taken;
    logic [XLEN-1:0] target;

    always_comb begin
        taken = jump | (branch & cond_true);
        // jalr clears bit 0 of rs1+imm; every other TargetSrc code is PC-relative
        if (target_src == TGT_RS1_IMM) begin
            target = {alu_result[XLEN-1:1], 1'b0};
        end else begin
            target = pc + imm_ext;
        end
        next_pc  = taken ? target : pc + XLEN'(32'd4);
        misalign = taken & target[1];
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// RV32 instruction fetch stage: PC register, one-outstanding imem requests, decoder handshake.
// Define IFU_MISALIGN_TRAP_EN to halt on a taken target with bit 1 set instead of aligning it.
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    input  logic            branch_i,
    input  logic            jump_i,
    input  logic [1:0]      target_src_i,
    input  logic            cond_true_i,
    input  logic [XLEN-1:0] imm_ext_i,
    input  logic [XLEN-1:0] alu_result_i,
    output logic            misalign_o
);

    ifu_state_e      state_q;
    logic            req_q;
    logic [XLEN-1:0] addr_q;
    logic [31:0]     instr_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc4_q;
    logic            valid_q;

    logic [XLEN-1:0] next_pc;
    logic [XLEN-1:0] fetch_pc;
    logic            misalign;

    next_pc_gen #(
        .XLEN(XLEN)
    ) u_next_pc_gen (
        .pc         (pc_q),
        .imm_ext    (imm_ext_i),
        .alu_result (alu_result_i),
        .branch     (branch_i),
        .jump       (jump_i),
        .cond_true  (cond_true_i),
        .target_src (target_src_i),
        .next_pc    (next_pc),
        .misalign   (misalign)
    );

    assign fetch_pc = {next_pc[XLEN-1:2], 2'b00};

`ifdef IFU_MISALIGN_TRAP_EN
    logic mis_q;
    assign misalign_o = mis_q;
`else
    logic unused_misalign;
    assign unused_misalign = ^{misalign, next_pc[1:0]};
    assign misalign_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_BOOT;
            req_q   <= 1'b0;
            addr_q  <= RESET_PC;
            instr_q <= NOP_INSTR;
            pc_q    <= RESET_PC;
            pc4_q   <= RESET_PC + XLEN'(32'd4);
            valid_q <= 1'b0;
`ifdef IFU_MISALIGN_TRAP_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_BOOT: begin
                    req_q   <= 1'b1;
                    addr_q  <= RESET_PC;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    req_q <= 1'b0;
                    if (imem_rvalid_i) begin
                        instr_q <= imem_rdata_i;
                        valid_q <= 1'b1;
                        state_q <= S_VALID;
                    end
                end
                S_VALID: begin
                    if (instr_ready_i) begin
                        valid_q <= 1'b0;
`ifdef IFU_MISALIGN_TRAP_EN
                        if (misalign) begin
                            // keep the offending target visible for the trap handler
                            pc_q    <= next_pc;
                            pc4_q   <= next_pc + XLEN'(32'd4);
                            mis_q   <= 1'b1;
                            state_q <= S_HALT;
                        end else begin
                            pc_q    <= fetch_pc;
                            pc4_q   <= fetch_pc + XLEN'(32'd4);
                            addr_q  <= fetch_pc;
                            req_q   <= 1'b1;
                            state_q <= S_WAIT;
                        end
`else
                        pc_q    <= fetch_pc;
                        pc4_q   <= fetch_pc + XLEN'(32'd4);
                        addr_q  <= fetch_pc;
                        req_q   <= 1'b1;
                        state_q <= S_WAIT;
`endif
                    end
                end
                S_HALT: begin
                    req_q <= 1'b0;
                end
                default: begin
                    state_q <= S_BOOT;
                end
            endcase
        end
    end

    assign imem_req_o    = req_q;
    assign imem_addr_o   = addr_q;
    assign instr_o       = instr_q;
    assign pc_o          = pc_q;
    assign pc_plus4_o    = pc4_q;
    assign instr_valid_o = valid_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed PC cases plus randomized fetch traffic.
// Expected PCs come from a transaction-level model of the fetch/retire sequence.
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b0;
    logic        branch_i = 1'b0;
    logic        jump_i = 1'b0;
    logic [1:0]  target_src_i = 2'b00;
    logic        cond_true_i = 1'b0;
    logic [31:0] imm_ext_i = '0;
    logic [31:0] alu_result_i = '0;
    logic        misalign_o;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_pc;

    instr_fetch_unit #(
        .XLEN     (32),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .pc_plus4_o    (pc_plus4_o),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .branch_i      (branch_i),
        .jump_i        (jump_i),
        .target_src_i  (target_src_i),
        .cond_true_i   (cond_true_i),
        .imm_ext_i     (imm_ext_i),
        .alu_result_i  (alu_result_i),
        .misalign_o    (misalign_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic junk_ctrl();
        branch_i     = 1'($urandom_range(0, 1));
        jump_i       = 1'($urandom_range(0, 1));
        cond_true_i  = 1'($urandom_range(0, 1));
        target_src_i = 2'($urandom_range(0, 3));
        imm_ext_i    = $urandom;
        alu_result_i = $urandom;
    endtask

    // Entered #1 after the edge that raised imem_req_o; leaves #1 after the retire edge.
    task automatic fetch_one(input int lat, input int stall, input logic br, input logic jp,
                             input logic ct, input logic [1:0] ts, input logic [31:0] imm,
                             input logic [31:0] alu, output bit halted);
        logic [31:0] word;
        logic [31:0] tgt;
        logic [31:0] nxt;
        bit          taken;
        halted = 1'b0;
        check("req_pulse", 32'(imem_req_o), 32'd1);
        check("req_addr", imem_addr_o, exp_pc);
        word = $urandom;
        for (int i = 1; i <= lat; i++) begin
            @(posedge clk);
            #1;
            check("one_outstanding", 32'(imem_req_o), 32'd0);
            check("no_early_valid", 32'(instr_valid_o), 32'd0);
            if (i == lat) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = word;
            end
        end
        @(posedge clk);
        #1;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = $urandom;
        check("valid", 32'(instr_valid_o), 32'd1);
        check("instr", instr_o, word);
        check("pc", pc_o, exp_pc);
        check("pc_plus4", pc_plus4_o, exp_pc + 32'd4);
        for (int s = 0; s < stall; s++) begin
            junk_ctrl();
            imem_rvalid_i = 1'($urandom_range(0, 1));
            imem_rdata_i  = $urandom;
            @(posedge clk);
            #1;
            check("stall_valid", 32'(instr_valid_o), 32'd1);
            check("stall_instr", instr_o, word);
            check("stall_pc", pc_o, exp_pc);
            check("stall_no_req", 32'(imem_req_o), 32'd0);
        end
        imem_rvalid_i = 1'b0;
        branch_i      = br;
        jump_i        = jp;
        cond_true_i   = ct;
        target_src_i  = ts;
        imm_ext_i     = imm;
        alu_result_i  = alu;
        instr_ready_i = 1'b1;
        taken = jp | (br & ct);
        tgt   = (ts == 2'b10) ? (alu & 32'hFFFF_FFFE) : exp_pc + imm;
        nxt   = taken ? tgt : exp_pc + 32'd4;
        @(posedge clk);
        #1;
        instr_ready_i = 1'b0;
        junk_ctrl();
`ifdef IFU_MISALIGN_TRAP_EN
        if (nxt[1]) begin
            check("halt_misalign", 32'(misalign_o), 32'd1);
            check("halt_pc", pc_o, nxt);
            check("halt_valid", 32'(instr_valid_o), 32'd0);
            for (int h = 0; h < 3; h++) begin
                check("halt_no_req", 32'(imem_req_o), 32'd0);
                @(posedge clk);
                #1;
            end
            halted = 1'b1;
            return;
        end
`endif
        exp_pc = {nxt[31:2], 2'b00};
        check("retire_valid", 32'(instr_valid_o), 32'd0);
        check("retire_pc", pc_o, exp_pc);
        check("retire_pc_plus4", pc_plus4_o, exp_pc + 32'd4);
        check("retire_misalign", 32'(misalign_o), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        exp_pc = RESET_PC;
    endtask

    task automatic step(input int lat, input int stall, input logic br, input logic jp,
                        input logic ct, input logic [1:0] ts, input logic [31:0] imm,
                        input logic [31:0] alu);
        bit h;
        fetch_one(lat, stall, br, jp, ct, ts, imm, alu, h);
        if (h) do_reset();
    endtask

    initial begin
        junk_ctrl();
        repeat (3) @(posedge clk);
        #1;
        check("rst_req", 32'(imem_req_o), 32'd0);
        check("rst_addr", imem_addr_o, RESET_PC);
        check("rst_instr", instr_o, 32'h0000_0013);
        check("rst_pc", pc_o, RESET_PC);
        check("rst_pc_plus4", pc_plus4_o, RESET_PC + 32'd4);
        check("rst_valid", 32'(instr_valid_o), 32'd0);
        check("rst_misalign", 32'(misalign_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        exp_pc = RESET_PC;

        step(1, 0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);           // 0x0 -> 0x4
        step(3, 4, 1'b0, 1'b1, 1'b0, 2'b01, 32'h0000_00FC, 32'h0);   // 0x4 -> 0x100
        step(1, 0, 1'b1, 1'b0, 1'b1, 2'b01, 32'hFFFF_FFF8, 32'h0);   // taken -8 -> 0xF8
        step(2, 1, 1'b0, 1'b1, 1'b0, 2'b01, 32'h0000_0008, 32'h0);   // back to 0x100
        step(1, 0, 1'b1, 1'b0, 1'b0, 2'b01, 32'hFFFF_FFF8, 32'h0);   // not taken -> 0x104
        step(1, 0, 1'b0, 1'b1, 1'b0, 2'b10, 32'h0, 32'hFFFF_FFFC);   // jalr -> 0xFFFFFFFC
        step(1, 0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);           // wraps to 0x0
        step(1, 0, 1'b0, 1'b1, 1'b0, 2'b10, 32'h0, 32'h0000_0203);   // misaligned jalr

        // Reset while a request is outstanding, stray response lands during reset/boot.
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_req", 32'(imem_req_o), 32'd0);
        check("midrst_pc", pc_o, RESET_PC);
        check("midrst_addr", imem_addr_o, RESET_PC);
        check("midrst_instr", instr_o, 32'h0000_0013);
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hDEAD_BEEF;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        imem_rvalid_i = 1'b0;
        check("stray_ignored", 32'(instr_valid_o), 32'd0);
        exp_pc = RESET_PC;
        step(1, 0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);

        for (int n = 0; n < 40; n++) begin
            step($urandom_range(1, 4), $urandom_range(0, 3),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 $urandom, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
